// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and types used by the padder.
package sha256_pkg;

  localparam int unsigned BLOCK_SIZE    = 256;
  localparam int unsigned MSG_MAX_BYTES = 55;
  localparam int unsigned CNT_W         = $clog2(MSG_MAX_BYTES + 1);

  typedef enum logic [2:0] {
    StCollect,
    StDrain,
    StPad,
    StStart,
    StWait,
    StOut
  } padder_state_e;

endpackage

// File: rtl/sha256_padder.sv
// Byte-stream front end for a single-block SHA-256 core: collects up to 55 bytes, pads,
// starts the core and holds the resulting digest until downstream takes it.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [7:0]              s_data_i,
  input  logic                    s_last_i,
  input  logic                    s_empty_i,
  output logic                    start_o,
  output logic [2*BLOCK_SIZE-1:0] msg_o,
  input  logic                    core_valid_i,
  input  logic [BLOCK_SIZE-1:0]   core_md_i,
  output logic                    digest_valid_o,
  input  logic                    digest_ready_i,
  output logic [BLOCK_SIZE-1:0]   digest_o,
  output logic                    err_o
);

  localparam int unsigned MsgW = 2 * BLOCK_SIZE;

  padder_state_e         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MsgW-1:0]       msg_q, msg_d;
  logic [BLOCK_SIZE-1:0] digest_q, digest_d;
  logic                  err_q, err_d;
  logic                  first_q, first_d;

  logic [MsgW-1:0]       pad_block;
  logic [8:0]            bit_hi;

  assign bit_hi = 9'(MsgW - 1) - {cnt_q, 3'b000};

  // Bytes below cnt are kept, byte cnt becomes the 0x80 marker, the rest zero.
  always_comb begin
    pad_block = msg_q;
    for (int unsigned i = 0; i <= MSG_MAX_BYTES; i++) begin
      if (CNT_W'(i) == cnt_q) begin
        pad_block[MsgW-1-8*i -: 8] = 8'h80;
      end else if (CNT_W'(i) > cnt_q) begin
        pad_block[MsgW-1-8*i -: 8] = 8'h00;
      end
    end
    pad_block[63:0] = 64'({cnt_q, 3'b000});
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    msg_d          = msg_q;
    digest_d       = digest_q;
    err_d          = 1'b0;
    first_d        = first_q;
    start_o        = 1'b0;
    digest_valid_o = 1'b0;

    case (state_q)
      StCollect: begin
        if (s_valid_i) begin
          if (s_last_i && s_empty_i) begin
            state_d = StPad;
          end else if (cnt_q == CNT_W'(MSG_MAX_BYTES)) begin
            // A 56th data byte cannot fit alongside the marker and length.
            if (s_last_i) begin
              err_d = 1'b1;
              cnt_d = '0;
              msg_d = '0;
            end else begin
              state_d = StDrain;
            end
          end else begin
            msg_d[bit_hi -: 8] = s_data_i;
            cnt_d              = cnt_q + 1'b1;
            if (s_last_i) begin
              state_d = StPad;
            end
          end
        end
      end
      StDrain: begin
        if (s_valid_i && s_last_i) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          msg_d   = '0;
          state_d = StCollect;
        end
      end
      StPad: begin
        msg_d   = pad_block;
        state_d = StStart;
      end
      StStart: begin
        start_o = 1'b1;
        first_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // The core's valid may still be high from the previous hash on the first cycle.
        first_d = 1'b0;
        if (!first_q && core_valid_i) begin
          digest_d = core_md_i;
          state_d  = StOut;
        end
      end
      StOut: begin
        digest_valid_o = 1'b1;
        if (digest_ready_i) begin
          cnt_d   = '0;
          msg_d   = '0;
          state_d = StCollect;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StCollect;
      cnt_q    <= '0;
      msg_q    <= '0;
      digest_q <= '0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      msg_q    <= msg_d;
      digest_q <= digest_d;
      err_q    <= err_d;
      first_q  <= first_d;
    end
  end

  assign s_ready_o = ~rst_i & ((state_q == StCollect) | (state_q == StDrain));
  assign msg_o     = msg_q;
  assign digest_o  = digest_q;
  assign err_o     = err_q;

endmodule
